// File: rtl/md_sequencer.sv
// Sequencer for the multi-cycle multiply and divide units: loads the selected
// unit, waits on its status, captures Hi/Lo and reports done or exceptions.
module md_sequencer #(
   parameter int TIMEOUT = 48,
   parameter int CNT_W   = 6
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        Start,
   input  logic        Op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic [31:0] Op_A,
   output logic [31:0] Op_B,
   output logic [1:0]  Div_State,
   output logic [1:0]  Mult_State,
   input  logic [1:0]  DivtoControl,
   input  logic [1:0]  MulttoControl,
   input  logic [31:0] Div_Hi,
   input  logic [31:0] Div_Lo,
   input  logic [31:0] Mult_Hi,
   input  logic [31:0] Mult_Lo,
   output logic [31:0] Hi,
   output logic [31:0] Lo,
   output logic        Busy,
   output logic        Done,
   output logic        Exception,
   output logic [1:0]  Exc_Cause
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_RUN,
      S_WRITE,
      S_EXC
   } state_t;

   localparam logic [1:0] UNIT_NEUTRAL = 2'b00;
   localparam logic [1:0] UNIT_LOAD    = 2'b01;
   localparam logic [1:0] UNIT_RUN     = 2'b10;
   localparam logic [1:0] CAUSE_DIV0   = 2'b01;
   localparam logic [1:0] CAUSE_TMO    = 2'b10;

   state_t             state_q, state_d;
   logic               op_q, op_d;
   logic [31:0]        op_a_q, op_a_d;
   logic [31:0]        op_b_q, op_b_d;
   logic [31:0]        hi_q, hi_d;
   logic [31:0]        lo_q, lo_d;
   logic               done_q, done_d;
   logic               exc_q, exc_d;
   logic [1:0]         cause_q, cause_d;
   logic [1:0]         pend_cause_q, pend_cause_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [CNT_W-1:0]   cnt_inc;
   logic               unit_done;
   logic [1:0]         sel_state;

   assign unit_done = op_q ? (DivtoControl == 2'b01) : (MulttoControl == 2'b01);
   assign cnt_inc   = cnt_q + CNT_W'(1);

   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      op_a_d       = op_a_q;
      op_b_d       = op_b_q;
      hi_d         = hi_q;
      lo_d         = lo_q;
      cnt_d        = cnt_q;
      pend_cause_d = pend_cause_q;
      done_d       = 1'b0;
      exc_d        = 1'b0;
      cause_d      = 2'b00;
      case (state_q)
         S_IDLE: begin
            if (Start) begin
               op_d   = Op;
               op_a_d = A;
               op_b_d = B;
               if (Op && (B == 32'd0)) begin
                  state_d      = S_EXC;
                  pend_cause_d = CAUSE_DIV0;
               end else begin
                  state_d = S_LOAD;
               end
            end
         end
         S_LOAD: begin
            cnt_d   = '0;
            state_d = S_RUN;
         end
         S_RUN: begin
            // Completion wins over a timeout that expires on the same cycle.
            cnt_d = cnt_inc;
            if (unit_done) begin
               state_d = S_WRITE;
            end else if (op_q && (DivtoControl == 2'b10)) begin
               state_d      = S_EXC;
               pend_cause_d = CAUSE_DIV0;
            end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
               state_d      = S_EXC;
               pend_cause_d = CAUSE_TMO;
            end
         end
         S_WRITE: begin
            hi_d    = op_q ? Div_Hi : Mult_Hi;
            lo_d    = op_q ? Div_Lo : Mult_Lo;
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         S_EXC: begin
            exc_d   = 1'b1;
            cause_d = pend_cause_q;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state_q      <= S_IDLE;
         op_q         <= 1'b0;
         op_a_q       <= '0;
         op_b_q       <= '0;
         hi_q         <= '0;
         lo_q         <= '0;
         cnt_q        <= '0;
         pend_cause_q <= 2'b00;
         done_q       <= 1'b0;
         exc_q        <= 1'b0;
         cause_q      <= 2'b00;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         op_a_q       <= op_a_d;
         op_b_q       <= op_b_d;
         hi_q         <= hi_d;
         lo_q         <= lo_d;
         cnt_q        <= cnt_d;
         pend_cause_q <= pend_cause_d;
         done_q       <= done_d;
         exc_q        <= exc_d;
         cause_q      <= cause_d;
      end
   end

   // WRITE keeps the unit running so its Hi/Lo stay valid until captured.
   always_comb begin
      sel_state = UNIT_NEUTRAL;
      if (state_q == S_LOAD) begin
         sel_state = UNIT_LOAD;
      end else if ((state_q == S_RUN) || (state_q == S_WRITE)) begin
         sel_state = UNIT_RUN;
      end
   end

   assign Div_State  = op_q ? sel_state : UNIT_NEUTRAL;
   assign Mult_State = op_q ? UNIT_NEUTRAL : sel_state;
   assign Op_A       = op_a_q;
   assign Op_B       = op_b_q;
   assign Hi         = hi_q;
   assign Lo         = lo_q;
   assign Busy       = (state_q != S_IDLE);
   assign Done       = done_q;
   assign Exception  = exc_q;
   assign Exc_Cause  = cause_q;

endmodule

// File: tb/tb_md_sequencer.sv
// Scoreboard bench for md_sequencer with a behavioural 33-cycle divider and a
// configurable multiplier stub.
module tb_md_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, op;
   logic [31:0] a, b;
   logic [31:0] op_a, op_b;
   logic [1:0]  div_state, mult_state;
   logic [1:0]  div_status, mult_status;
   logic [31:0] div_hi, div_lo, mult_hi, mult_lo;
   logic [31:0] hi, lo;
   logic        busy, done, exc;
   logic [1:0]  exc_cause;

   typedef struct {
      bit          is_exc;
      logic [1:0]  cause;
      logic [31:0] hi;
      logic [31:0] lo;
      int          cyc;
   } exp_t;

   exp_t        exp_q[$];
   int          pass_cnt  = 0;
   int          total_cnt = 0;
   int          cyc       = 0;
   bit          div_seen, mult_seen;

   logic [31:0] dv_a, dv_b;
   int          dv_cnt;
   int          mul_limit = 10;
   int          mul_cnt;
   logic [31:0] stub_hi = '0, stub_lo = '0;

   md_sequencer dut (
      .Clock(clk), .Reset(rst_n), .Start(start), .Op(op), .A(a), .B(b),
      .Op_A(op_a), .Op_B(op_b), .Div_State(div_state), .Mult_State(mult_state),
      .DivtoControl(div_status), .MulttoControl(mult_status),
      .Div_Hi(div_hi), .Div_Lo(div_lo), .Mult_Hi(mult_hi), .Mult_Lo(mult_lo),
      .Hi(hi), .Lo(lo), .Busy(busy), .Done(done), .Exception(exc),
      .Exc_Cause(exc_cause)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Divider: finishes on its 33rd run edge and holds the result while in run.
   always @(posedge clk) begin
      if (div_state == 2'b01) begin
         dv_a <= op_a; dv_b <= op_b; dv_cnt <= 0; div_status <= 2'b00;
      end else if (div_state == 2'b10) begin
         dv_cnt <= dv_cnt + 1;
         if (dv_cnt + 1 == 33) begin
            if (dv_b == 32'd0) begin
               div_status <= 2'b10;
            end else begin
               div_status <= 2'b01;
               div_hi     <= dv_a % dv_b;
               div_lo     <= dv_a / dv_b;
            end
         end
      end else begin
         dv_cnt <= 0; div_status <= 2'b00;
      end
   end

   // Multiplier stub: done after mul_limit run edges; 0 means it never completes.
   always @(posedge clk) begin
      if (mult_state == 2'b10) begin
         mul_cnt <= mul_cnt + 1;
         if (mul_limit != 0 && mul_cnt + 1 == mul_limit) begin
            mult_status <= 2'b01; mult_hi <= stub_hi; mult_lo <= stub_lo;
         end
      end else begin
         mul_cnt <= 0; mult_status <= 2'b00;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
      total_cnt++;
      if (act === expv) pass_cnt++;
      else $display("[TB] FAIL %s: got %h expected %h", name, act, expv);
   endtask

   task automatic applyStimulus(input bit op_i, input logic [31:0] a_i, input logic [31:0] b_i,
                                input bit push, input bit is_exc, input logic [1:0] cause,
                                input logic [31:0] ehi, input logic [31:0] elo, input int lat);
      exp_t e;
      start = 1'b1; op = op_i; a = a_i; b = b_i;
      if (push) begin
         e.is_exc = is_exc; e.cause = cause; e.hi = ehi; e.lo = elo; e.cyc = cyc + lat;
         exp_q.push_back(e);
      end
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic waitEvent(input string name, input int max_cyc);
      int n = 0;
      while (!(done || exc) && n < max_cyc) begin
         @(negedge clk);
         n++;
         div_seen  |= (div_state != 2'b00);
         mult_seen |= (mult_state != 2'b00);
      end
      checkOutput({name, "_completes"}, {31'd0, (done || exc)}, 32'd1);
   endtask

   always @(negedge clk) begin
      if (rst_n && (done || exc)) begin
         if (exp_q.size() == 0) begin
            total_cnt++;
            $display("[TB] FAIL unexpected_pulse: got done=%0d exc=%0d expected none", done, exc);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            checkOutput("sb_done",  {31'd0, done}, {31'd0, !e.is_exc});
            checkOutput("sb_exc",   {31'd0, exc},  {31'd0, e.is_exc});
            checkOutput("sb_cause", {30'd0, exc_cause}, {30'd0, e.cause});
            checkOutput("sb_hi",    hi, e.hi);
            checkOutput("sb_lo",    lo, e.lo);
            checkOutput("sb_cycle", cyc, e.cyc);
            checkOutput("sb_busy",  {31'd0, busy}, 32'd0);
         end
      end
   end

   initial begin
      #300000;
      $display("[TB] FAIL global_timeout: got no finish expected finish");
      $fatal(1, "[TB] simulation timeout");
   end

   initial begin
      bit saw_done;
      rst_n = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0;
      repeat (2) @(negedge clk);
      checkOutput("rst_busy", {31'd0, busy}, 32'd0);
      checkOutput("rst_hi", hi, 32'd0);
      checkOutput("rst_lo", lo, 32'd0);
      checkOutput("rst_op_a", op_a, 32'd0);
      checkOutput("rst_states", {28'd0, div_state, mult_state}, 32'd0);
      checkOutput("rst_pulses", {29'd0, done, exc, |exc_cause}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Reset asserted mid-divide
      applyStimulus(1'b1, 32'd100, 32'd7, 1'b0, 1'b0, 2'b00, '0, '0, 0);
      repeat (10) @(negedge clk);
      checkOutput("mid_div_running", {30'd0, div_state}, 32'd2);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("rst_mid_div_state", {30'd0, div_state}, 32'd0);
      checkOutput("rst_mid_busy", {31'd0, busy}, 32'd0);
      checkOutput("rst_mid_hilo", hi | lo, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      saw_done = 1'b0;
      repeat (45) begin
         @(negedge clk);
         saw_done |= done;
      end
      checkOutput("rst_mid_no_done", {31'd0, saw_done}, 32'd0);

      // DIV 100/7 -> q=14, r=2
      applyStimulus(1'b1, 32'd100, 32'd7, 1'b1, 1'b0, 2'b00, 32'd2, 32'd14, 37);
      checkOutput("div_load_state", {30'd0, div_state}, 32'd1);
      checkOutput("div_load_mult", {30'd0, mult_state}, 32'd0);
      @(negedge clk);
      checkOutput("div_run_state", {30'd0, div_state}, 32'd2);
      waitEvent("div100", 100);
      @(negedge clk);
      checkOutput("div_after_state", {30'd0, div_state}, 32'd0);

      // DIV by zero: exception, divider untouched, Hi/Lo kept
      div_seen = 1'b0;
      applyStimulus(1'b1, 32'd5, 32'd0, 1'b1, 1'b1, 2'b01, 32'd2, 32'd14, 2);
      div_seen |= (div_state != 2'b00);
      waitEvent("div0", 10);
      checkOutput("div0_state_idle", {31'd0, div_seen}, 32'd0);

      // MULT stub with 10 run cycles
      mul_limit = 10; stub_hi = 32'hFFFF_FFFF; stub_lo = 32'hFFFF_FFFE;
      applyStimulus(1'b0, 32'hFFFF_FFFF, 32'd2, 1'b1, 1'b0, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 14);
      checkOutput("mul_load_state", {30'd0, mult_state}, 32'd1);
      @(negedge clk);
      checkOutput("mul_run_state", {30'd0, mult_state}, 32'd2);
      div_seen = 1'b0;
      waitEvent("mul10", 50);
      checkOutput("mul_div_quiet", {31'd0, div_seen}, 32'd0);
      @(negedge clk);
      checkOutput("mul_after_state", {30'd0, mult_state}, 32'd0);

      // MULT that never completes -> timeout
      mul_limit = 0;
      applyStimulus(1'b0, 32'd3, 32'd4, 1'b1, 1'b1, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 51);
      waitEvent("mul_tmo", 200);
      checkOutput("tmo_mult_state", {30'd0, mult_state}, 32'd0);
      @(negedge clk);

      // Start while busy is ignored; Start on the Done cycle is accepted
      applyStimulus(1'b1, 32'd200, 32'd9, 1'b1, 1'b0, 2'b00, 32'd2, 32'd22, 37);
      repeat (5) @(negedge clk);
      start = 1'b1; op = 1'b0; a = 32'd1; b = 32'd1;
      @(negedge clk);
      start = 1'b0;
      checkOutput("busy_start_op_a", op_a, 32'd200);
      checkOutput("busy_start_op_b", op_b, 32'd9);
      waitEvent("div200", 100);
      mul_limit = 10; stub_hi = 32'd0; stub_lo = 32'd15;
      applyStimulus(1'b0, 32'd3, 32'd5, 1'b1, 1'b0, 2'b00, 32'd0, 32'd15, 14);
      checkOutput("b2b_load_state", {30'd0, mult_state}, 32'd1);
      checkOutput("b2b_busy", {31'd0, busy}, 32'd1);
      checkOutput("b2b_op_a", op_a, 32'd3);
      waitEvent("b2b_mul", 50);

      repeat (3) @(negedge clk);
      checkOutput("sb_drained", exp_q.size(), 32'd0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
